// File: rtl/rv_multicycle_core.sv
// Multicycle RV32I-subset core (ADD/SUB/AND/OR/SLT, ADDI/ANDI/ORI/SLTI, LW, SW, BEQ)
// with one shared instruction/data memory port, run/single-step control,
// an illegal-instruction halt and a register debug read port.
module rv_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  input  logic [4:0]        dbg_sel,
  output logic [31:0]       dbg_data,
  output logic [31:0]       pc_dbg,
  output logic [31:0]       instr_dbg,
  output logic [2:0]        state_dbg,
  output logic              retire,
  output logic              halted
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpLoad = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpBr   = 7'b1100011;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  state_e      state_q, state_d;
  logic [31:0] pc_q, old_pc_q, ir_q, a_q, b_q, imm_q, alu_out_q, mdr_q;
  logic        step_pending_q;
  logic [31:0] regs_q [32];

  // Instruction fields
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;
  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  logic is_r, is_i, is_lw, is_sw, is_beq, legal;
  logic [2:0]  alu_op;
  logic [31:0] imm_d;

  // Instruction decode: class, legality, ALU operation and immediate
  always_comb begin
    is_r   = 1'b0;
    is_i   = 1'b0;
    is_lw  = 1'b0;
    is_sw  = 1'b0;
    is_beq = 1'b0;
    legal  = 1'b0;
    alu_op = AluAdd;
    imm_d  = {{20{ir_q[31]}}, ir_q[31:20]};
    unique case (opcode)
      OpR: begin
        is_r = 1'b1;
        if (funct7 == 7'b0000000) begin
          legal = 1'b1;
          case (funct3)
            3'b000:  alu_op = AluAdd;
            3'b111:  alu_op = AluAnd;
            3'b110:  alu_op = AluOr;
            3'b010:  alu_op = AluSlt;
            default: legal = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          legal  = 1'b1;
          alu_op = AluSub;
        end
      end
      OpI: begin
        is_i  = 1'b1;
        legal = 1'b1;
        case (funct3)
          3'b000:  alu_op = AluAdd;
          3'b111:  alu_op = AluAnd;
          3'b110:  alu_op = AluOr;
          3'b010:  alu_op = AluSlt;
          default: legal = 1'b0;
        endcase
      end
      OpLoad: begin
        is_lw = 1'b1;
        legal = (funct3 == 3'b010);
      end
      OpStore: begin
        is_sw = 1'b1;
        legal = (funct3 == 3'b010);
        imm_d = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      end
      OpBr: begin
        is_beq = 1'b1;
        legal  = (funct3 == 3'b000);
        alu_op = AluSub;
        imm_d  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      end
      default: legal = 1'b0;
    endcase
  end

  // ALU on latched operands
  logic [31:0] src_b, alu_res;
  always_comb begin
    src_b = (is_i || is_lw || is_sw) ? imm_q : b_q;
    case (alu_op)
      AluAdd:  alu_res = a_q + src_b;
      AluSub:  alu_res = a_q - src_b;
      AluAnd:  alu_res = a_q & src_b;
      AluOr:   alu_res = a_q | src_b;
      AluSlt:  alu_res = {31'b0, $signed(a_q) < $signed(src_b)};
      default: alu_res = 32'b0;
    endcase
  end

  logic go;
  assign go = run | step_pending_q;

  logic [31:0] addr_full;

  // Next state and memory/retire outputs
  always_comb begin
    state_d   = state_q;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    addr_full = pc_q;
    retire    = 1'b0;
    case (state_q)
      StFetch: begin
        if (go) begin
          mem_re = 1'b1;
          if (mem_ready) state_d = StDecode;
        end
      end
      StDecode: state_d = legal ? StExec : StHalt;
      StExec: begin
        if (is_beq) begin
          retire  = 1'b1;
          state_d = StFetch;
        end else if (is_lw || is_sw) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        addr_full = alu_out_q;
        mem_re    = is_lw;
        mem_we    = ~is_lw;
        if (mem_ready) begin
          retire  = ~is_lw;
          state_d = is_lw ? StWb : StFetch;
        end
      end
      StWb: begin
        retire  = 1'b1;
        state_d = StFetch;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // State, datapath and register file update
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StFetch;
      pc_q           <= RESET_PC;
      old_pc_q       <= '0;
      ir_q           <= '0;
      a_q            <= '0;
      b_q            <= '0;
      imm_q          <= '0;
      alu_out_q      <= '0;
      mdr_q          <= '0;
      step_pending_q <= 1'b0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      // Leaving FETCH consumes the pending step, even if a new pulse arrives then
      if (state_q == StFetch && state_d != StFetch) step_pending_q <= 1'b0;
      else if (step) step_pending_q <= 1'b1;
      case (state_q)
        StFetch: begin
          if (go && mem_ready) begin
            ir_q     <= mem_rdata;
            old_pc_q <= pc_q;
            pc_q     <= pc_q + 32'd4;
          end
        end
        StDecode: begin
          a_q   <= (rs1 == 5'd0) ? 32'b0 : regs_q[rs1];
          b_q   <= (rs2 == 5'd0) ? 32'b0 : regs_q[rs2];
          imm_q <= imm_d;
        end
        StExec: begin
          alu_out_q <= alu_res;
          if (is_beq && alu_res == 32'b0) pc_q <= old_pc_q + imm_q;
        end
        StMem: begin
          if (is_lw && mem_ready) mdr_q <= mem_rdata;
        end
        StWb: begin
          if (rd != 5'd0) regs_q[rd] <= is_lw ? mdr_q : alu_out_q;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = addr_full[ADDR_W-1:0];
  assign mem_wdata = b_q;
  assign dbg_data  = (dbg_sel == 5'd0) ? 32'b0 : regs_q[dbg_sel];
  assign pc_dbg    = pc_q;
  assign instr_dbg = ir_q;
  assign state_dbg = state_q;
  assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_rv_multicycle_core.sv
// Testbench for rv_multicycle_core: shared memory model with programmable wait
// states, per-instruction vector table, store scoreboard and step/halt/reset sequences.
module tb_rv_multicycle_core;

  logic        clk = 1'b0;
  logic        rst, run, step;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, dbg_data, pc_dbg, instr_dbg;
  logic        mem_re, mem_we, mem_ready, retire, halted;
  logic [4:0]  dbg_sel;
  logic [2:0]  state_dbg;

  rv_multicycle_core #(.RESET_PC(32'h0), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .dbg_sel(dbg_sel), .dbg_data(dbg_data),
    .pc_dbg(pc_dbg), .instr_dbg(instr_dbg), .state_dbg(state_dbg), .retire(retire),
    .halted(halted)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model: word array, ready after wait_n stall cycles per request
  logic [31:0] mem [64];
  int          wait_n = 0;
  int          wcnt   = 0;
  assign mem_ready = (mem_re || mem_we) && (wcnt >= wait_n);
  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (rst || !(mem_re || mem_we) || mem_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (!rst && mem_we && mem_ready) mem[mem_addr[7:2]] <= mem_wdata;
  end

  // Store scoreboard: expected writes queued when the SW vector is driven
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t wr_q[$];

  // Stall stability tracking
  logic        stab_pend = 1'b0;
  logic [31:0] st_addr;
  logic        st_re, st_we;
  int          stab_err = 0;

  always @(negedge clk) begin
    wr_t e;
    if (!rst && mem_we && mem_ready) begin
      n_tests++;
      if (wr_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_write: unexpected write addr=%h data=%h", mem_addr, mem_wdata);
      end else begin
        e = wr_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          n_fail++;
          $display("FAIL sb_write: got addr=%h data=%h expected addr=%h data=%h",
                   mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
    if (stab_pend && !rst) begin
      if (mem_addr !== st_addr || mem_re !== st_re || mem_we !== st_we) stab_err++;
    end
    stab_pend = !rst && (mem_re || mem_we) && !mem_ready;
    st_addr   = mem_addr;
    st_re     = mem_re;
    st_we     = mem_we;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Count cycles of one instruction, ending on its retire cycle (bounded)
  task automatic run_one(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!retire && cyc < 100);
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    int          wt;
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [31:0] pc;
    logic        do_wr;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic [31:0] addr, input logic [31:0] instr, input int wt,
                         input int cyc, input logic [4:0] rd, input logic [31:0] val,
                         input logic [31:0] pc, input logic do_wr,
                         input logic [31:0] wa, input logic [31:0] wd);
    vec_t v;
    v.addr = addr; v.instr = instr; v.wt = wt; v.cyc = cyc; v.rd = rd; v.val = val;
    v.pc = pc; v.do_wr = do_wr; v.wr_addr = wa; v.wr_data = wd;
    vecs.push_back(v);
  endtask

  localparam logic [6:0] OI = 7'b0010011;

  initial begin
    int cyc;
    int bad;
    int rets;
    vec_t v;

    // Execution-order vector table: addr, instr, wait, cycles, rd, value, next PC, store
    add_vec(32'h00, enc_i(12'd5, 5'd0, 3'b000, 5'd1, OI), 0, 4, 5'd1, 32'd5, 32'h04, 0, 0, 0);
    add_vec(32'h04, enc_i(12'd7, 5'd0, 3'b000, 5'd2, OI), 0, 4, 5'd2, 32'd7, 32'h08, 0, 0, 0);
    add_vec(32'h08, enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 0, 4, 5'd3, 32'd12, 32'h0C, 0, 0, 0);
    add_vec(32'h0C, enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4), 0, 4, 5'd4, 32'hFFFF_FFFE, 32'h10,
            0, 0, 0);
    add_vec(32'h10, enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd5), 0, 4, 5'd5, 32'd5, 32'h14, 0, 0, 0);
    add_vec(32'h14, enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd6), 0, 4, 5'd6, 32'd7, 32'h18, 0, 0, 0);
    add_vec(32'h18, enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd7), 0, 4, 5'd7, 32'd1, 32'h1C, 0, 0, 0);
    add_vec(32'h1C, enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd0), 0, 4, 5'd0, 32'd0, 32'h20, 0, 0, 0);
    add_vec(32'h20, enc_i(12'hFFF, 5'd4, 3'b010, 5'd9, OI), 0, 4, 5'd9, 32'd1, 32'h24, 0, 0, 0);
    add_vec(32'h24, enc_i(12'd6, 5'd3, 3'b111, 5'd10, OI), 0, 4, 5'd10, 32'd4, 32'h28, 0, 0, 0);
    add_vec(32'h28, enc_i(12'hFF0, 5'd0, 3'b110, 5'd11, OI), 0, 4, 5'd11, 32'hFFFF_FFF0, 32'h2C,
            0, 0, 0);
    add_vec(32'h2C, enc_s(12'd8, 5'd3, 5'd0), 2, 8, 5'd3, 32'd12, 32'h30, 1, 32'd8, 32'd12);
    add_vec(32'h30, enc_i(12'd8, 5'd0, 3'b010, 5'd8, 7'b0000011), 2, 9, 5'd8, 32'd12, 32'h34,
            0, 0, 0);
    add_vec(32'h34, enc_b(13'd8, 5'd2, 5'd1), 0, 3, 5'd0, 32'd0, 32'h38, 0, 0, 0);
    add_vec(32'h38, enc_b(13'd8, 5'd1, 5'd1), 0, 3, 5'd0, 32'd0, 32'h40, 0, 0, 0);
    add_vec(32'h40, enc_b(13'h1FFC, 5'd0, 5'd12), 0, 3, 5'd12, 32'd0, 32'h3C, 0, 0, 0);
    add_vec(32'h3C, enc_i(12'd1, 5'd0, 3'b000, 5'd12, OI), 0, 4, 5'd12, 32'd1, 32'h40, 0, 0, 0);
    add_vec(32'h40, enc_b(13'h1FFC, 5'd0, 5'd12), 0, 3, 5'd12, 32'd1, 32'h44, 0, 0, 0);

    for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    #1;
    foreach (vecs[i]) mem[vecs[i].addr[7:2]] <= vecs[i].instr;
    mem[32'h44 >> 2] <= enc_i(12'd3, 5'd0, 3'b000, 5'd13, OI);
    mem[32'h48 >> 2] <= 32'h0000_007F;

    // Reset state
    rst = 1'b1; run = 1'b1; step = 1'b0; dbg_sel = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc_dbg, 32'h0);
    check("rst_state", {29'b0, state_dbg}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_retire", {31'b0, retire}, 32'd0);
    check("rst_ir", instr_dbg, 32'h0);
    check("rst_mem_re", {31'b0, mem_re}, 32'd1);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    rst = 1'b0;

    // Vector table
    foreach (vecs[i]) begin
      v = vecs[i];
      wait_n = v.wt;
      if (v.do_wr) wr_q.push_back('{addr: v.wr_addr, data: v.wr_data});
      run_one(cyc);
      check($sformatf("v%0d_cycles", i), cyc, v.cyc);
      @(posedge clk);
      #1;
      dbg_sel = v.rd;
      #1;
      check($sformatf("v%0d_x%0d", i, v.rd), dbg_data, v.val);
      check($sformatf("v%0d_pc", i), pc_dbg, v.pc);
    end

    // Step mode: idle with no step
    run = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_re || mem_we || retire) bad++;
    end
    check("idle_no_req", bad, 0);
    check("idle_pc", pc_dbg, 32'h44);

    // One step pulse retires exactly one instruction
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    run_one(cyc);
    check("step_retired", {31'b0, retire}, 32'd1);
    @(posedge clk);
    #1;
    dbg_sel = 5'd13;
    #1;
    check("step_x13", dbg_data, 32'd3);
    rets = 0;
    bad  = 0;
    repeat (20) begin
      @(negedge clk);
      if (retire) rets++;
      if (mem_re || mem_we) bad++;
    end
    check("step_extra_retire", rets, 0);
    check("step_extra_req", bad, 0);
    check("step_pc", pc_dbg, 32'h48);

    // Illegal opcode halts; only reset exits
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    repeat (4) @(negedge clk);
    check("halt_flag", {31'b0, halted}, 32'd1);
    check("halt_state", {29'b0, state_dbg}, 32'd5);
    run = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      step = ~step;
      if (mem_re || mem_we || !halted) bad++;
    end
    step = 1'b0;
    check("halt_stuck", bad, 0);

    // Reset while an LW waits in MEM
    @(posedge clk);
    #1;
    rst = 1'b1;
    mem[0] <= enc_i(12'd8, 5'd0, 3'b010, 5'd14, 7'b0000011);
    repeat (2) @(posedge clk);
    #1;
    check("rst2_halted", {31'b0, halted}, 32'd0);
    wait_n = 10;
    rst = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (state_dbg != 3'd3 && cyc < 100);
    check("lw_reach_mem", {29'b0, state_dbg}, 32'd3);
    repeat (2) @(negedge clk);
    check("lw_mem_addr", mem_addr, 32'd8);
    check("lw_mem_re", {31'b0, mem_re}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    run = 1'b0;
    #1;
    check("midmem_state", {29'b0, state_dbg}, 32'd0);
    check("midmem_pc", pc_dbg, 32'h0);
    check("midmem_mem_re", {31'b0, mem_re}, 32'd0);
    check("midmem_mem_we", {31'b0, mem_we}, 32'd0);
    bad = 0;
    for (int r = 0; r < 32; r++) begin
      dbg_sel = r[4:0];
      #1;
      if (dbg_data !== 32'h0) bad++;
    end
    check("midmem_regs_zero", bad, 0);
    repeat (20) @(negedge clk);
    dbg_sel = 5'd14;
    #1;
    check("midmem_x14", dbg_data, 32'h0);

    check("stall_stable", stab_err, 0);
    check("sb_drained", wr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_multicycle_core.md
# rv_multicycle_core

Parametrised multicycle RV32I-subset core that replaces the single-cycle board datapath. It uses one shared instruction/data memory behind a ready handshake, so program and data can live in one external RAM with wait states. The instruction set is ADD/SUB/AND/OR/SLT, ADDI/ANDI/ORI/SLTI, LW, SW and BEQ. It adds run/single-step control, an illegal-instruction halt and a selectable register debug port that feeds the LCD/HEX top level.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- ADDR_W, 32: width of mem_addr; the PC is truncated to its ADDR_W LSBs when driven out.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  1 = free-running; 0 = single-step mode.
- step  in  1  one-cycle pulse; requests the next instruction in step mode.
- mem_addr  out  ADDR_W  byte address (PC in FETCH, ALU result in MEM).
- mem_re  out  1  read request.
- mem_we  out  1  write request.
- mem_wdata  out  32  store data (rs2).
- mem_rdata  in  32  read data; valid when mem_ready=1.
- mem_ready  in  1  memory completes the current request this cycle.
- dbg_sel  in  5  register index for dbg_data.
- dbg_data  out  32  combinational read of x[dbg_sel]; x0 reads 0.
- pc_dbg  out  32  architectural PC.
- instr_dbg  out  32  instruction register (IR).
- state_dbg  out  3  FSM state encoding.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  set on illegal instruction.

## Operation
- FSM states and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- mem_re, mem_we and mem_addr are combinational from the state and registers. They hold stable until mem_ready.

State behaviour:
- FETCH:
  - go = run | step_pending. While go=0: mem_re=0 and the core stays in FETCH.
  - While go=1: mem_re=1, mem_addr=PC.
  - On mem_ready: IR<=mem_rdata, OldPC<=PC, PC<=PC+4, step_pending<=0, then DECODE.
- DECODE:
  - Latch A=x[rs1] and B=x[rs2].
  - Latch imm: I-type imm[11:0], S-type {imm[11:5],imm[4:0]}, B-type {imm[12:1],0}, each sign-extended to 32 bits.
  - Unknown opcode, or a funct3/funct7 combination outside the subset: go to HALT.
- EXEC:
  - ALU codes: 000 add, 001 sub, 010 and, 011 or, 101 slt (signed).
  - SrcB = imm for I/LW/SW, otherwise B. ALUOut is latched.
  - BEQ: subtract. If zero, PC<=OldPC+immB. Pulse retire, then FETCH.
  - LW/SW go to MEM; R/I-type go to WB.
- MEM:
  - mem_addr=ALUOut.
  - LW: mem_re=1; on mem_ready, MDR<=mem_rdata, then WB.
  - SW: mem_we=1, mem_wdata=B; on mem_ready, pulse retire, then FETCH.
- WB:
  - x[rd] <= (LW ? MDR : ALUOut); writes with rd=0 are discarded.
  - Pulse retire, then FETCH.
- HALT: halted=1, no memory requests. Only rst leaves HALT.

Register file and step control:
- 32x32 registers; x0 always reads 0.
- step_pending is set by step=1 in any state and cleared on leaving FETCH. It holds at most one pending step; extra pulses while pending are lost.
- Arithmetic wraps modulo 2^32. No misalignment checks; mem_addr is passed through unmodified.

## Timing
Reset:
- rst sampled high in any state, including mid-MEM with a request outstanding, applies on that edge:
  - state=FETCH, PC=RESET_PC.
  - IR, OldPC, A, B, ALUOut, MDR and all registers = 0.
  - step_pending=0, halted=0, retire=0.
- In the cycle after reset, mem_re = run and mem_we = 0. An abandoned memory request is not completed.

Latency with mem_ready tied to 1:
- BEQ: 3 cycles (FETCH, DECODE, EXEC).
- R/I-type: 4 cycles.
- SW: 4 cycles.
- LW: 5 cycles.
- Each memory wait cycle adds 1 cycle to FETCH or MEM.

Other timing rules:
- retire is high for exactly the last cycle of an instruction. Register and PC updates are visible on the next cycle.
- A step pulse arriving in the same cycle as FETCH with run=0 starts the fetch in the following cycle.
- Changing run between 0 and 1 mid-instruction does not affect the current instruction; it is sampled only in FETCH.

## Test plan
- Reset and ADDI: reset with RESET_PC=0, ADDI x1,x0,5 at address 0, mem_ready=1. Required: pc_dbg=0 after reset, retire at cycle 4, dbg_sel=1 reads 5, pc_dbg=4.
- R-type: x1=5, x2=7, then ADD x3, SUB x4 (x1-x2), AND x5, OR x6, SLT x7. Required: x3=12, x4=0xFFFF_FFFE, x5=5, x6=7, x7=1. ADD x0,x1,x2 leaves x0=0.
- Memory with wait states: SW x3,8(x0) then LW x8,8(x0), with mem_ready delayed 2 cycles on every request. Required: write at address 8 with data 12, x8=12, SW takes 8 cycles and LW takes 9; mem_addr/mem_we stay stable while waiting.
- BEQ: BEQ x1,x1,-4 at 0x10 branches to 0x0C in 3 cycles; BEQ x1,x2,+8 is not taken and the PC becomes 0x14.
- Step and halt: run=0, no step, for 20 cycles. Required: mem_re=0 and the PC is unchanged. One step pulse retires exactly one instruction. Opcode 0x7F gives halted=1, no memory requests, and no exit until rst.
- Reset mid-MEM: assert rst while an LW waits in MEM. Required: next state FETCH, PC=RESET_PC, all registers 0, and the LW target register is never written.
